// File: rtl/bayer_win5x5_taps.sv
// bayer_win5x5_taps
// -----------------------------------------------------------------------------
// Raster-to-window front end for the 5x5 Bayer demosaic kernels. Raw 12-bit
// Bayer pixels stream in, four lines are held in line memory. For every pixel
// of the frame the block emits the nine taps of the centre-weight-6 kernel,
// each as {pixel[11:0], one-hot CFA tag[3:0]}. Taps outside the frame are 0.
//
// Ports
//   clk, rst_n               pixel clock, asynchronous active-low reset
//   sof                      start of frame, qualified by din_vld & din_rdy
//   din_vld / din / din_rdy  input pixel stream
//   dout_vld                 one-cycle pulse per output tap set
//   dout_eof                 with dout_vld: last output of the frame
//   pix_6_weight0            centre (0,0)
//   pix_2_weight0..3         (-1,-1), (-1,+1), (+1,-1), (+1,+1)
//   pix_1_and_half_weight0..3 (-2,0), (0,-2), (0,+2), (+2,0)
//   dbg_state                current FSM state (IDLE=0, FILL=1, RUN=2, FLUSH=3)
//
// Handshake: a pixel is transferred in a cycle where din_vld and din_rdy are
// both high; din_rdy depends only on the FSM state, never on din_vld. The
// output side has no backpressure.
//
// Pipeline: the accepted pixel (or a flush step) is shifted into the window on
// the accepting edge together with the centre coordinates; the tap words are
// masked/tagged and registered on the next edge, so dout_vld is high in the
// second cycle after the accept.
// -----------------------------------------------------------------------------
module bayer_win5x5_taps #(
    parameter int IMG_W = 1920,
    parameter int IMG_H = 1080,
    parameter int BAYER = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sof,
    input  logic        din_vld,
    input  logic [11:0] din,
    output logic        din_rdy,
    output logic        dout_vld,
    output logic        dout_eof,
    output logic [15:0] pix_6_weight0,
    output logic [15:0] pix_2_weight0,
    output logic [15:0] pix_2_weight1,
    output logic [15:0] pix_2_weight2,
    output logic [15:0] pix_2_weight3,
    output logic [15:0] pix_1_and_half_weight0,
    output logic [15:0] pix_1_and_half_weight1,
    output logic [15:0] pix_1_and_half_weight2,
    output logic [15:0] pix_1_and_half_weight3,
    output logic [1:0]  dbg_state
);

    localparam int D  = 2 * IMG_W + 2;
    localparam int N  = IMG_W * IMG_H;
    localparam int CW = $clog2(N + 1);
    localparam int RW = $clog2(IMG_H);
    localparam int XW = $clog2(IMG_W);

    localparam logic [CW-1:0] IDX_FILL_END = CW'(D - 1);
    localparam logic [CW-1:0] IDX_LAST     = CW'(N - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_LAST2    = RW'(IMG_H - 2);
    localparam logic [XW-1:0] COL_LAST     = XW'(IMG_W - 1);
    localparam logic [XW-1:0] COL_LAST2    = XW'(IMG_W - 2);
    localparam logic          PH_ROW       = 1'(BAYER >> 1);
    localparam logic          PH_COL       = 1'(BAYER);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [RW-1:0]   cen_row_q, cen_row_d;
    logic [XW-1:0]   cen_col_q, cen_col_d;
    logic [XW-1:0]   ptr_q;

    logic            acc;
    logic            shift_en;
    logic [11:0]     shift_px;
    logic            out_en;
    logic            cen_last;

    // Window storage: lm_q[k] delays the stream by (k+1) lines, h_q[r][c] is
    // the value of line-delay r seen c steps ago.
    logic [11:0]     lm_q [4][IMG_W];
    logic [11:0]     h_q  [5][5];
    logic [11:0]     v    [5];

    logic            s1_vld_q, s1_eof_q;
    logic [RW-1:0]   s1_row_q;
    logic [XW-1:0]   s1_col_q;

    logic            dout_vld_q, dout_eof_q;
    logic [15:0]     tap_q [9];
    logic [15:0]     tap_d [9];

    assign din_rdy   = (state_q != S_FLUSH);
    assign acc       = din_vld & din_rdy;
    assign cen_last  = (cen_row_q == ROW_LAST) && (cen_col_q == COL_LAST);
    assign dbg_state = state_q;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        cen_row_d = cen_row_q;
        cen_col_d = cen_col_q;
        shift_en  = 1'b0;
        shift_px  = din;
        out_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (acc && sof) begin
                    shift_en  = 1'b1;
                    in_cnt_d  = CW'(1);
                    cen_row_d = '0;
                    cen_col_d = '0;
                    state_d   = S_FILL;
                end
            end
            S_FILL, S_RUN: begin
                if (acc) begin
                    shift_en = 1'b1;
                    if (sof) begin
                        // Abort: this pixel is index 0 of a new frame.
                        in_cnt_d  = CW'(1);
                        cen_row_d = '0;
                        cen_col_d = '0;
                        state_d   = S_FILL;
                    end else begin
                        in_cnt_d = in_cnt_q + CW'(1);
                        if (state_q == S_FILL) begin
                            if (in_cnt_q == IDX_FILL_END) state_d = S_RUN;
                        end else begin
                            out_en = 1'b1;
                            if (cen_col_q == COL_LAST) begin
                                cen_col_d = '0;
                                cen_row_d = cen_row_q + RW'(1);
                            end else begin
                                cen_col_d = cen_col_q + XW'(1);
                            end
                            if (in_cnt_q == IDX_LAST) state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                // Shift dummy zeros so the remaining centres reach the window.
                shift_en = 1'b1;
                shift_px = '0;
                out_en   = 1'b1;
                if (cen_last) begin
                    cen_row_d = '0;
                    cen_col_d = '0;
                    state_d   = S_IDLE;
                end else if (cen_col_q == COL_LAST) begin
                    cen_col_d = '0;
                    cen_row_d = cen_row_q + RW'(1);
                end else begin
                    cen_col_d = cen_col_q + XW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_cnt_q  <= '0;
            cen_row_q <= '0;
            cen_col_q <= '0;
            ptr_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_eof_q  <= 1'b0;
            s1_row_q  <= '0;
            s1_col_q  <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            cen_row_q <= cen_row_d;
            cen_col_q <= cen_col_d;
            s1_vld_q  <= out_en;
            s1_eof_q  <= out_en & cen_last;
            if (out_en) begin
                s1_row_q <= cen_row_q;
                s1_col_q <= cen_col_q;
            end
            if (shift_en) ptr_q <= (ptr_q == COL_LAST) ? '0 : ptr_q + XW'(1);
        end
    end

    // ------------------------------------------------------- line memories
    always_comb begin
        v[0] = shift_px;
        for (int r = 1; r < 5; r++) v[r] = lm_q[r-1][ptr_q];
    end

    // Contents are don't-care after reset; stale data is always masked.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int r = 0; r < 4; r++) lm_q[r][ptr_q] <= v[r];
            for (int r = 0; r < 5; r++) begin
                h_q[r][0] <= v[r];
                for (int k = 1; k < 5; k++) h_q[r][k] <= h_q[r][k-1];
            end
        end
    end

    // ------------------------------------------------- masking and tagging
    logic       ru1, ru2, rd1, rd2, cl1, cl2, cr1, cr2;
    logic       pr, pc;
    logic [3:0] tag_same, tag_diag;

    always_comb begin
        ru1 = (s1_row_q != '0);
        ru2 = (s1_row_q > RW'(1));
        rd1 = (s1_row_q != ROW_LAST);
        rd2 = (s1_row_q < ROW_LAST2);
        cl1 = (s1_col_q != '0);
        cl2 = (s1_col_q > XW'(1));
        cr1 = (s1_col_q != COL_LAST);
        cr2 = (s1_col_q < COL_LAST2);
        pr  = s1_row_q[0] ^ PH_ROW;
        pc  = s1_col_q[0] ^ PH_COL;
        // Axial taps are an even distance away, so share the centre colour;
        // diagonals flip both parities.
        tag_same = 4'b0001 << {pr, pc};
        tag_diag = 4'b0001 << {~pr, ~pc};

        tap_d[0] = {h_q[2][2], tag_same};
        tap_d[1] = (ru1 && cl1) ? {h_q[3][3], tag_diag} : 16'h0000;
        tap_d[2] = (ru1 && cr1) ? {h_q[3][1], tag_diag} : 16'h0000;
        tap_d[3] = (rd1 && cl1) ? {h_q[1][3], tag_diag} : 16'h0000;
        tap_d[4] = (rd1 && cr1) ? {h_q[1][1], tag_diag} : 16'h0000;
        tap_d[5] = ru2 ? {h_q[4][2], tag_same} : 16'h0000;
        tap_d[6] = cl2 ? {h_q[2][4], tag_same} : 16'h0000;
        tap_d[7] = cr2 ? {h_q[2][0], tag_same} : 16'h0000;
        tap_d[8] = rd2 ? {h_q[0][2], tag_same} : 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_vld_q <= 1'b0;
            dout_eof_q <= 1'b0;
            for (int i = 0; i < 9; i++) tap_q[i] <= 16'h0000;
        end else begin
            dout_vld_q <= s1_vld_q;
            dout_eof_q <= s1_vld_q & s1_eof_q;
            if (s1_vld_q) begin
                for (int i = 0; i < 9; i++) tap_q[i] <= tap_d[i];
            end
        end
    end

    assign dout_vld               = dout_vld_q;
    assign dout_eof               = dout_eof_q;
    assign pix_6_weight0          = tap_q[0];
    assign pix_2_weight0          = tap_q[1];
    assign pix_2_weight1          = tap_q[2];
    assign pix_2_weight2          = tap_q[3];
    assign pix_2_weight3          = tap_q[4];
    assign pix_1_and_half_weight0 = tap_q[5];
    assign pix_1_and_half_weight1 = tap_q[6];
    assign pix_1_and_half_weight2 = tap_q[7];
    assign pix_1_and_half_weight3 = tap_q[8];

endmodule

// File: tb/tb_bayer_win5x5_taps.sv
// Bench for bayer_win5x5_taps: two instances (BAYER 0 and 3) share one
// stimulus stream; a frame-array reference model predicts every tap set.
module tb_bayer_win5x5_taps;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int D  = 2 * W + 2;
    localparam int EW = 32 + 1 + 288;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sof = 1'b0;
    logic        din_vld = 1'b0;
    logic [11:0] din = '0;

    logic        rdy0, vld0, eof0, rdy3, vld3, eof3;
    logic [1:0]  st0, st3;
    logic [15:0] t0 [9];
    logic [15:0] t3 [9];

    bayer_win5x5_taps #(.IMG_W(W), .IMG_H(H), .BAYER(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sof(sof), .din_vld(din_vld), .din(din),
        .din_rdy(rdy0), .dout_vld(vld0), .dout_eof(eof0),
        .pix_6_weight0(t0[0]),
        .pix_2_weight0(t0[1]), .pix_2_weight1(t0[2]),
        .pix_2_weight2(t0[3]), .pix_2_weight3(t0[4]),
        .pix_1_and_half_weight0(t0[5]), .pix_1_and_half_weight1(t0[6]),
        .pix_1_and_half_weight2(t0[7]), .pix_1_and_half_weight3(t0[8]),
        .dbg_state(st0)
    );

    bayer_win5x5_taps #(.IMG_W(W), .IMG_H(H), .BAYER(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .sof(sof), .din_vld(din_vld), .din(din),
        .din_rdy(rdy3), .dout_vld(vld3), .dout_eof(eof3),
        .pix_6_weight0(t3[0]),
        .pix_2_weight0(t3[1]), .pix_2_weight1(t3[2]),
        .pix_2_weight2(t3[3]), .pix_2_weight3(t3[4]),
        .pix_1_and_half_weight0(t3[5]), .pix_1_and_half_weight1(t3[6]),
        .pix_1_and_half_weight2(t3[7]), .pix_1_and_half_weight3(t3[8]),
        .dbg_state(st3)
    );

    // ------------------------------------------------------ clock block
    always #5 clk = ~clk;

    // -------------------------------------------------------- scoreboard
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [11:0]   img [N];
    int            m_idx = 0;
    bit            m_active = 1'b0;
    int            m_flush_left = 0;
    logic [EW-1:0] exp_q [$];
    logic [143:0]  last0 = '0;
    logic [143:0]  last3 = '0;
    int            vld_cnt = 0;
    int            eof_cnt = 0;

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] tap(int r, int c, int bay);
        int pr, pc;
        if (r < 0 || r >= H || c < 0 || c >= W) return 16'h0000;
        pr = (r % 2) ^ ((bay >> 1) & 1);
        pc = (c % 2) ^ (bay & 1);
        return {img[r*W + c], 4'(1 << (2*pr + pc))};
    endfunction

    function automatic logic [143:0] taps_of(int n, int bay);
        int r, c;
        r = n / W;
        c = n % W;
        return {tap(r, c, bay),
                tap(r-1, c-1, bay), tap(r-1, c+1, bay),
                tap(r+1, c-1, bay), tap(r+1, c+1, bay),
                tap(r-2, c, bay), tap(r, c-2, bay),
                tap(r, c+2, bay), tap(r+2, c, bay)};
    endfunction

    // A step taken before posedge cyc+1 shows up after posedge cyc+2.
    task automatic schedule(input int n);
        exp_q.push_back({32'(cyc + 2), 1'(n == N - 1), taps_of(n, 0), taps_of(n, 3)});
    endtask

    task automatic check_outputs();
        logic [EW-1:0] e;
        logic          ev, ee;
        ev = 1'b0;
        ee = 1'b0;
        if (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] == 32'(cyc)) begin
            e     = exp_q.pop_front();
            ev    = 1'b1;
            ee    = e[288];
            last0 = e[287:144];
            last3 = e[143:0];
        end
        check("dout_vld_b0", vld0, ev);
        check("dout_vld_b3", vld3, ev);
        check("dout_eof_b0", eof0, ee);
        check("dout_eof_b3", eof3, ee);
        check("taps_b0", {t0[0], t0[1], t0[2], t0[3], t0[4], t0[5], t0[6], t0[7], t0[8]}, last0);
        check("taps_b3", {t3[0], t3[1], t3[2], t3[3], t3[4], t3[5], t3[6], t3[7], t3[8]}, last3);
        if (vld0) vld_cnt++;
        if (eof0) eof_cnt++;
    endtask

    // ------------------------------------------------------ driver tasks
    // Called at a negedge: drive inputs, step the model, advance one clock.
    task automatic tick(input logic vld, input logic s, input logic [11:0] px);
        din_vld = vld;
        sof     = s;
        din     = px;
        check("din_rdy_b0", rdy0, m_flush_left == 0);
        check("din_rdy_b3", rdy3, m_flush_left == 0);
        if (m_flush_left > 0) begin
            schedule(N - m_flush_left);
            m_flush_left--;
        end else if (vld) begin
            if (s) begin
                m_active = 1'b1;
                img[0]   = px;
                m_idx    = 1;
            end else if (m_active) begin
                img[m_idx] = px;
                if (m_idx >= D) schedule(m_idx - D);
                m_idx++;
                if (m_idx == N) begin
                    m_active     = 1'b0;
                    m_flush_left = D;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        din_vld = 1'b0;
        sof     = 1'b0;
        #1;
        check("rst_vld", {vld0, vld3}, 2'b00);
        check("rst_eof", {eof0, eof3}, 2'b00);
        check("rst_taps_b0", {t0[0], t0[1], t0[2], t0[3], t0[4], t0[5], t0[6], t0[7], t0[8]}, 144'h0);
        check("rst_taps_b3", {t3[0], t3[1], t3[2], t3[3], t3[4], t3[5], t3[6], t3[7], t3[8]}, 144'h0);
        check("rst_rdy", {rdy0, rdy3}, 2'b11);
        check("rst_state", {st0, st3}, 4'h0);
        exp_q.delete();
        m_active     = 1'b0;
        m_flush_left = 0;
        last0        = '0;
        last3        = '0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode 0: row*16+col gapless, 1: same with a gap every other cycle,
    // 2: random pixels with random gaps. stop_at < 0 sends the whole frame.
    task automatic send_frame(input int mode, input int stop_at);
        logic [11:0] px;
        vld_cnt = 0;
        eof_cnt = 0;
        for (int idx = 0; idx < N && idx != stop_at; idx++) begin
            if (mode == 2) px = 12'($urandom_range(0, 4095));
            else           px = 12'((idx / W) * 16 + idx % W);
            if (mode == 2) begin
                repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom_range(0, 1)), 12'($urandom));
            end
            tick(1'b1, idx == 0, px);
            if (mode == 1) tick(1'b0, 1'b0, 12'($urandom));
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_flush_left > 0 || exp_q.size() > 0) && guard < 200) begin
            tick(1'($urandom_range(0, 1)), 1'b0, 12'($urandom));
            guard++;
        end
        check("drain_pending", 144'(exp_q.size() + m_flush_left), 144'h0);
    endtask

    task automatic check_counts();
        check("frame_outputs", 144'(vld_cnt), 144'(N));
        check("frame_eofs", 144'(eof_cnt), 144'd1);
    endtask

    // ------------------------------------------------------------- main
    initial begin
        #2;
        @(negedge clk);
        do_reset();

        // pixels without sof while idle are dropped
        repeat (3) tick(1'b1, 1'b0, 12'($urandom));

        send_frame(0, -1); drain(); check_counts();
        send_frame(1, -1); drain(); check_counts();
        send_frame(2, -1); drain(); check_counts();
        send_frame(2, -1); drain(); check_counts();

        // abort at accepted index 30, then a full frame
        send_frame(0, 30);
        send_frame(2, -1); drain();

        // reset in the middle of the flush, then a normal frame
        send_frame(2, -1);
        repeat (5) tick(1'b1, 1'b0, 12'($urandom));
        do_reset();
        repeat (3) tick(1'b0, 1'b0, 12'h0);
        send_frame(0, -1); drain(); check_counts();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
